// File: rtl/int_arbiter_pkg.sv
// rtl/int_arbiter_pkg.sv - shared state encoding and constants for the interrupt arbiter
package int_arbiter_pkg;

  // Default number of external interrupt lines and index width
  localparam int N_IRQ_DEF = 6;
  localparam int ID_W_DEF  = 3;

  // Cause.ExcCode value recorded by CP0 when an interrupt is taken
  localparam logic [4:0] EXC_CODE_INT = 5'b00000;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/int_sync_edge.sv
// rtl/int_sync_edge.sv - two-flop synchronizer and rising-edge detector for one interrupt line
module int_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic irq_raw,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  // Synchronize the raw line and keep the previous synchronized value for edge detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= irq_raw;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

endmodule

// File: rtl/int_arbiter.sv
// rtl/int_arbiter.sv - interrupt arbiter/sequencer for CP0; INT_ROUND_ROBIN_EN selects round-robin winner search
module int_arbiter
  import int_arbiter_pkg::*;
#(
  parameter int N_IRQ = N_IRQ_DEF,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] im,
  input  logic             ie,
  input  logic             exc_busy,
  input  logic             int_ack,
  input  logic             eret,
  output logic             int_req,
  output logic [ID_W-1:0]  int_id,
  output logic [N_IRQ-1:0] int_pending,
  output logic             in_service
);

  arb_state_t       state;
  arb_state_t       state_next;
  logic [ID_W-1:0]  id_next;
  logic             ack_take;
  logic [N_IRQ-1:0] rise_vec;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] ack_clr;
  logic [N_IRQ-1:0] eligible;
  logic [ID_W-1:0]  search_start;

  // First requesting line found when scanning upward from start, wrapping at N_IRQ
  function automatic logic [ID_W-1:0] pick_winner(input logic [N_IRQ-1:0] req,
                                                   input logic [ID_W-1:0]  start);
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] sel;
    logic            found;
    int              idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N_IRQ; k++) begin
      idx = (int'(start) + k) % N_IRQ;
      sel = ID_W'(idx);
      if (!found && req[sel]) begin
        win   = sel;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  genvar g;
  generate
    for (g = 0; g < N_IRQ; g++) begin : g_line
      int_sync_edge u_sync (
        .clock   (clock),
        .reset   (reset),
        .irq_raw (irq_in[g]),
        .rise    (rise_vec[g])
      );
    end
  endgenerate

  // One-hot clear of the acknowledged line
  always_comb begin
    ack_clr = '0;
    if (ack_take) begin
      ack_clr[int_id] = 1'b1;
    end
  end

  // Pending latches: a new edge wins over a simultaneous acknowledge clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~ack_clr) | rise_vec;
    end
  end

  assign eligible = (ie && !exc_busy) ? (pending & im) : '0;

`ifdef INT_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr;

  // Last-granted line; the next search begins just after it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= ID_W'(N_IRQ - 1);
    end else if (ack_take) begin
      rr_ptr <= int_id;
    end
  end

  assign search_start = (rr_ptr >= ID_W'(N_IRQ - 1)) ? '0 : rr_ptr + ID_W'(1);
`else
  assign search_start = '0;
`endif

  // Sequencer state and frozen winner index
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      int_id <= '0;
    end else begin
      state  <= state_next;
      int_id <= id_next;
    end
  end

  // Next state: arbitrate in IDLE, hold in REQ until ack or withdraw, wait for eret in SERVICE
  always_comb begin
    state_next = state;
    id_next    = int_id;
    ack_take   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|eligible) begin
          id_next    = pick_winner(eligible, search_start);
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          ack_take   = 1'b1;
          state_next = ST_SERVICE;
        end else if (!eligible[int_id]) begin
          state_next = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (eret) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign int_req     = (state == ST_REQ);
  assign in_service  = (state == ST_SERVICE);
  assign int_pending = pending;

endmodule
